// File: rtl/cov_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cov_bram_arbiter
// Description : Arbitrates a single-port BRAM between one writer and one
//               reader. Reads stay blocked until every entry has been written
//               at least once since the last rst/clr. Contested cycles
//               alternate between the two sides using a round-robin pointer.
//               Read data is returned through a RD_LATENCY-deep valid pipeline.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               clr                 - restart matrix fill (drops written mask)
//               wr_req/addr/data    - writer request, held until wr_gnt
//               wr_gnt              - combinational write grant
//               rd_req/addr         - reader request, held until rd_gnt
//               rd_gnt              - combinational read grant
//               rd_valid, rd_data   - registered read return
//               matrix_ready        - all entries written since last clr/rst
//               bram_*              - single-port BRAM port A
// Revision    : 1.0 - initial release
// ============================================================================
module cov_bram_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 2,
    parameter int RD_LATENCY = 2    // legal 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              matrix_ready,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    input  logic [DATA_W-1:0] bram_douta
);

    localparam int c_ENTRIES = 1 << ADDR_W;

    localparam logic [0:0] c_FILL  = 1'b0;
    localparam logic [0:0] c_READY = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [c_ENTRIES-1:0]  r_mask;
    logic [c_ENTRIES-1:0]  w_mask_next;
    logic                  r_ptr;        // 0: write wins a tie, 1: read wins
    logic                  w_wr_gnt;
    logic                  w_rd_gnt;
    logic                  w_rd_ok;
    logic [RD_LATENCY-1:0] r_pipe;       // one bit per read in flight
    logic                  r_rd_valid;
    logic [DATA_W-1:0]     r_rd_data;

    // Grants: rst and clr suppress everything; only READY allows reads.
    always_comb begin
        w_wr_gnt = 1'b0;
        w_rd_gnt = 1'b0;
        w_rd_ok  = (r_state == c_READY);
        if (!rst && !clr) begin
            if (wr_req && rd_req && w_rd_ok) begin
                if (r_ptr) w_rd_gnt = 1'b1;
                else       w_wr_gnt = 1'b1;
            end else if (wr_req) begin
                w_wr_gnt = 1'b1;
            end else if (rd_req && w_rd_ok) begin
                w_rd_gnt = 1'b1;
            end
        end
    end

    // Next mask and state. The FSM looks at the mask value being written at
    // this edge, so READY appears the cycle after the final missing entry
    // is granted.
    always_comb begin
        w_mask_next  = r_mask;
        w_state_next = r_state;
        if (clr) begin
            w_mask_next  = '0;
            w_state_next = c_FILL;
        end else begin
            if (w_wr_gnt) w_mask_next[wr_addr] = 1'b1;
            if (r_state == c_FILL && (&w_mask_next)) w_state_next = c_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_FILL;
            r_mask  <= '0;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
            if (w_wr_gnt)      r_ptr <= 1'b1;
            else if (w_rd_gnt) r_ptr <= 1'b0;
        end
    end

    // Read return pipeline. clr deliberately leaves it alone so reads issued
    // before a clr still complete; only rst drops them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_pipe[0] <= w_rd_gnt;
            for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
            r_rd_valid <= r_pipe[RD_LATENCY-1];
            if (r_pipe[RD_LATENCY-1]) r_rd_data <= bram_douta;
        end
    end

    assign wr_gnt       = w_wr_gnt;
    assign rd_gnt       = w_rd_gnt;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign matrix_ready = (r_state == c_READY);
    assign bram_ena     = w_wr_gnt | w_rd_gnt;
    assign bram_wea     = w_wr_gnt;
    assign bram_addra   = w_wr_gnt ? wr_addr : (w_rd_gnt ? rd_addr : '0);
    assign bram_dina    = wr_data;

endmodule
`default_nettype wire

// File: tb/tb_cov_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cov_bram_arbiter
// Description : Self-checking bench for cov_bram_arbiter with a behavioural
//               BRAM model and a per-cycle vector table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cov_bram_arbiter;

    localparam int c_DW  = 32;
    localparam int c_AW  = 2;
    localparam int c_LAT = 2;

    logic            clk = 1'b0;
    logic            rst, clr, wr_req, rd_req;
    logic [c_AW-1:0] wr_addr, rd_addr;
    logic [c_DW-1:0] wr_data;
    logic            wr_gnt, rd_gnt, rd_valid, matrix_ready;
    logic [c_DW-1:0] rd_data;
    logic            bram_ena, bram_wea;
    logic [c_AW-1:0] bram_addra;
    logic [c_DW-1:0] bram_dina, bram_douta;

    always #5 clk = ~clk;

    cov_bram_arbiter #(.DATA_W(c_DW), .ADDR_W(c_AW), .RD_LATENCY(c_LAT)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .matrix_ready(matrix_ready),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
        .bram_dina(bram_dina), .bram_douta(bram_douta)
    );

    // BRAM model: douta shows the addressed word c_LAT edges after the access.
    logic [c_DW-1:0] mem   [1 << c_AW];
    logic [c_DW-1:0] stage [c_LAT];
    always @(posedge clk) begin
        if (bram_ena) begin
            if (bram_wea) mem[bram_addra] <= bram_dina;
            stage[0] <= mem[bram_addra];
        end
        for (int i = 1; i < c_LAT; i++) stage[i] <= stage[i-1];
    end
    assign bram_douta = stage[c_LAT-1];

    typedef struct {
        logic            wr;
        logic [c_AW-1:0] wa;
        logic [c_DW-1:0] wd;
        logic            rd;
        logic [c_AW-1:0] ra;
        logic            cl;
        logic            ewg;
        logic            erg;
        logic            erdy;
        logic            ev;
        logic [c_DW-1:0] ed;
    } vec_t;

    localparam int c_NV = 41;
    vec_t tbl [c_NV];

    int n_pass  = 0;
    int n_total = 0;

    function automatic vec_t mk(logic wr, logic [c_AW-1:0] wa, logic [c_DW-1:0] wd,
                                logic rd, logic [c_AW-1:0] ra, logic cl,
                                logic ewg, logic erg, logic erdy, logic ev,
                                logic [c_DW-1:0] ed);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra; v.cl = cl;
        v.ewg = ewg; v.erg = erg; v.erdy = erdy; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    endtask

    task automatic drive(input logic wr, input logic [c_AW-1:0] wa,
                         input logic [c_DW-1:0] wd, input logic rd,
                         input logic [c_AW-1:0] ra, input logic cl);
        wr_req = wr; wr_addr = wa; wr_data = wd;
        rd_req = rd; rd_addr = ra; clr = cl;
    endtask

    initial begin
        // reads blocked before fill
        for (int i = 0; i < 10; i++)
            tbl[i] = mk(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        // fill all four entries
        tbl[10] = mk(1'b1, 2'd0, 32'h11, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[11] = mk(1'b1, 2'd1, 32'h22, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[12] = mk(1'b1, 2'd2, 32'h33, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[13] = mk(1'b1, 2'd3, 32'h44, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[14] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        // single read of addr 2, returned three cycles later
        tbl[15] = mk(1'b0, 2'd0, 32'h0,  1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tbl[16] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[17] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[18] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33);
        tbl[19] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33);
        // contested: W,R,W,R
        tbl[20] = mk(1'b1, 2'd3, 32'h55, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33);
        tbl[21] = mk(1'b1, 2'd3, 32'h55, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h33);
        tbl[22] = mk(1'b1, 2'd3, 32'h55, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33);
        tbl[23] = mk(1'b1, 2'd3, 32'h55, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h33);
        tbl[24] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11);
        tbl[25] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11);
        tbl[26] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11);
        // write then immediate read of the same entry, then back-to-back reads
        tbl[27] = mk(1'b1, 2'd3, 32'h99, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h11);
        tbl[28] = mk(1'b0, 2'd0, 32'h0,  1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11);
        tbl[29] = mk(1'b0, 2'd0, 32'h0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11);
        tbl[30] = mk(1'b0, 2'd0, 32'h0,  1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h11);
        // clr with both requests: no grant; in-flight reads still return
        tbl[31] = mk(1'b1, 2'd0, 32'hAA, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h99);
        tbl[32] = mk(1'b0, 2'd0, 32'h0,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11);
        tbl[33] = mk(1'b0, 2'd0, 32'h0,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22);
        tbl[34] = mk(1'b0, 2'd0, 32'h0,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22);
        tbl[35] = mk(1'b1, 2'd0, 32'h11, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22);
        tbl[36] = mk(1'b0, 2'd0, 32'h0,  1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22);
        // refill and issue a read that reset will drop
        tbl[37] = mk(1'b1, 2'd1, 32'h22, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22);
        tbl[38] = mk(1'b1, 2'd2, 32'h33, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22);
        tbl[39] = mk(1'b1, 2'd3, 32'h44, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22);
        tbl[40] = mk(1'b0, 2'd0, 32'h0,  1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h22);

        // reset with requests pending
        rst = 1'b1;
        drive(1'b1, 2'd0, 32'h0, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        chk("rst_wr_gnt", -1, 32'(wr_gnt), 32'd0);
        chk("rst_rd_gnt", -1, 32'(rd_gnt), 32'd0);
        chk("rst_ena",    -1, 32'(bram_ena), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_valid", -1, 32'(rd_valid), 32'd0);
        chk("rst_data",  -1, rd_data, 32'd0);
        chk("rst_ready", -1, 32'(matrix_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < c_NV; i++) begin
            drive(tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].rd, tbl[i].ra, tbl[i].cl);
            @(negedge clk);
            chk("wr_gnt",       i, 32'(wr_gnt),       32'(tbl[i].ewg));
            chk("rd_gnt",       i, 32'(rd_gnt),       32'(tbl[i].erg));
            chk("bram_ena",     i, 32'(bram_ena),     32'(tbl[i].ewg | tbl[i].erg));
            chk("bram_wea",     i, 32'(bram_wea),     32'(tbl[i].ewg));
            chk("matrix_ready", i, 32'(matrix_ready), 32'(tbl[i].erdy));
            chk("rd_valid",     i, 32'(rd_valid),     32'(tbl[i].ev));
            chk("rd_data",      i, rd_data,           tbl[i].ed);
            if (tbl[i].ewg) begin
                chk("wr_addra", i, 32'(bram_addra), 32'(tbl[i].wa));
                chk("wr_dina",  i, bram_dina,       tbl[i].wd);
            end
            if (tbl[i].erg) chk("rd_addra", i, 32'(bram_addra), 32'(tbl[i].ra));
            @(posedge clk); #1;
        end

        // rst one cycle after the read grant of the last row
        rst = 1'b1;
        drive(1'b1, 2'd1, 32'h77, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        chk("midrst_wr_gnt", 100, 32'(wr_gnt),   32'd0);
        chk("midrst_rd_gnt", 100, 32'(rd_gnt),   32'd0);
        chk("midrst_ena",    100, 32'(bram_ena), 32'd0);
        chk("midrst_wea",    100, 32'(bram_wea), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_valid", 101 + k, 32'(rd_valid),     32'd0);
            chk("post_rst_data",  101 + k, rd_data,           32'd0);
            chk("post_rst_ready", 101 + k, 32'(matrix_ready), 32'd0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
